// File: rtl/cc_branch_unit_pkg.sv
// Shared LC-3b datapath types for the condition-code / branch logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [2:0]  lc3b_nzp;
   typedef logic [2:0]  lc3b_reg;

   // Z flag set: makes BRz / BRnzp taken straight out of reset
   localparam lc3b_nzp CC_RESET = 3'b010;

endpackage

// File: rtl/cc_branch_unit_leaf.sv
// Leaf blocks: flag generator, branch condition compare, loadable register.
// Latency: gencc/cccomp combinational; register one cycle.
// Backpressure: none; inputs are taken when presented.
module gencc
   import lc3b_types::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] in,
   output lc3b_nzp          out
);

   logic n;
   logic z;

   assign n   = in[WIDTH-1];
   assign z   = (in == '0);
   // exactly one of n/z/p is set for any value
   assign out = {n, z, ~n & ~z};

endmodule

module cccomp
   import lc3b_types::*;
(
   input  lc3b_nzp cc_in,
   input  lc3b_nzp dest,
   output logic    branch_enable
);

   // nzp mask of 000 never matches, 111 always matches one flag
   assign branch_enable = |(cc_in & dest);

endmodule

module register #(
   parameter int              width     = 3,
   parameter logic [width-1:0] reset_val = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [width-1:0] in,
   output logic [width-1:0] out
);

   // async reset and sync clear both return to the reset value; load otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         out <= reset_val;
      else if (clr)
         out <= reset_val;
      else if (load)
         out <= in;
   end

endmodule

// File: rtl/cc_branch_unit.sv
// Condition-code register, branch resolution, mispredict detect and stats.
// Latency: value_in->cc_out 1 cycle; branch/mispredict combinational; counters 1 cycle.
// Backpressure: none; every input is sampled for the single cycle it is asserted.
module cc_branch_unit
   import lc3b_types::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld_cc,
   input  logic [DATA_WIDTH-1:0] value_in,
   input  logic [2:0]            nzp_in,
   input  logic                  br_valid,
   input  logic                  predict_in,
   output logic [2:0]            cc_out,
   output logic                  branch_enable,
   output logic                  mispredict,
   output logic [CNT_WIDTH-1:0]  branch_count,
   output logic [CNT_WIDTH-1:0]  mispredict_count
);

   lc3b_nzp cc_next;
   lc3b_nzp cc_q;

   gencc #(
      .WIDTH (DATA_WIDTH)
   ) u_gencc (
      .in  (value_in),
      .out (cc_next)
   );

   register #(
      .width     (3),
      .reset_val (CC_RESET)
   ) u_cc_reg (
      .clk  (clk),
      .rst  (rst),
      .clr  (1'b0),
      .load (ld_cc),
      .in   (cc_next),
      .out  (cc_q)
   );

   // branch sees the flags held before any same-cycle load
   cccomp u_cccomp (
      .cc_in         (cc_q),
      .dest          (nzp_in),
      .branch_enable (branch_enable)
   );

   assign cc_out     = cc_q;
   assign mispredict = br_valid & (branch_enable != predict_in);

   // branch statistics, wrapping naturally at the counter width
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (br_valid) begin
         branch_count <= branch_count + 1'b1;
         if (mispredict)
            mispredict_count <= mispredict_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_cc_branch_unit.sv
module tb_cc_branch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ld_cc = 1'b0;
   logic [15:0] value_in = '0;
   logic [2:0]  nzp_in = '0;
   logic        br_valid = 1'b0;
   logic        predict_in = 1'b0;

   logic [2:0]  cc_out;
   logic        branch_enable;
   logic        mispredict;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   logic [2:0]  cc_s;
   logic        be_s;
   logic        mp_s;
   logic [2:0]  bc_s;
   logic [2:0]  mc_s;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [2:0]  cc_m;
   logic [31:0] bc_m;
   logic [31:0] mc_m;

   always #5 clk = ~clk;

   cc_branch_unit dut (
      .clk              (clk),
      .rst              (rst),
      .ld_cc            (ld_cc),
      .value_in         (value_in),
      .nzp_in           (nzp_in),
      .br_valid         (br_valid),
      .predict_in       (predict_in),
      .cc_out           (cc_out),
      .branch_enable    (branch_enable),
      .mispredict       (mispredict),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   // narrow-counter instance so wraparound is reachable in a short run
   cc_branch_unit #(.DATA_WIDTH(16), .CNT_WIDTH(3)) dut_small (
      .clk              (clk),
      .rst              (rst),
      .ld_cc            (ld_cc),
      .value_in         (value_in),
      .nzp_in           (nzp_in),
      .br_valid         (br_valid),
      .predict_in       (predict_in),
      .cc_out           (cc_s),
      .branch_enable    (be_s),
      .mispredict       (mp_s),
      .branch_count     (bc_s),
      .mispredict_count (mc_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] flags_of(input logic [15:0] v);
      if ($signed(v) < 0)  return 3'b100;
      else if (v == 16'd0) return 3'b010;
      else                 return 3'b001;
   endfunction

   function automatic logic taken(input logic [2:0] cc, input logic [2:0] nzp);
      // taken when any requested condition matches the held flag
      return (nzp[2] && cc == 3'b100) || (nzp[1] && cc == 3'b010) ||
             (nzp[0] && cc == 3'b001);
   endfunction

   task automatic model_reset();
      cc_m = 3'b010;
      bc_m = 0;
      mc_m = 0;
   endtask

   task automatic step(input logic ld, input logic [15:0] v, input logic [2:0] nzp,
                       input logic bv, input logic pred);
      logic exp_be;
      logic exp_mp;
      @(negedge clk);
      ld_cc = ld; value_in = v; nzp_in = nzp; br_valid = bv; predict_in = pred;
      #1;
      exp_be = taken(cc_m, nzp);
      exp_mp = bv && (exp_be != pred);
      chk("branch_enable", {31'd0, branch_enable}, {31'd0, exp_be});
      chk("mispredict", {31'd0, mispredict}, {31'd0, exp_mp});
      @(posedge clk);
      if (bv) begin
         bc_m = bc_m + 1;
         if (exp_mp) mc_m = mc_m + 1;
      end
      if (ld) cc_m = flags_of(v);
      #1;
      chk("cc_out", {29'd0, cc_out}, {29'd0, cc_m});
      chk("branch_count", branch_count, bc_m);
      chk("mispredict_count", mispredict_count, mc_m);
      chk("small_branch_count", {29'd0, bc_s}, {29'd0, bc_m[2:0]});
      chk("small_mispredict_count", {29'd0, mc_s}, {29'd0, mc_m[2:0]});
   endtask

   initial begin
      logic [15:0] sweep [5];
      logic [15:0] cc_vals [3];
      logic [15:0] rv;
      sweep[0] = 16'h8000; sweep[1] = 16'h0000; sweep[2] = 16'h0001;
      sweep[3] = 16'hFFFF; sweep[4] = 16'h7FFF;
      cc_vals[0] = 16'h8000; cc_vals[1] = 16'h0000; cc_vals[2] = 16'h0001;

      // power-on reset
      rst = 1'b1;
      model_reset();
      #12;
      chk("por_cc", {29'd0, cc_out}, 32'd2);
      chk("por_branch_count", branch_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // gencc sweep
      for (int i = 0; i < 5; i++) step(1'b1, sweep[i], 3'b000, 1'b0, 1'b0);

      // cccomp: every mask against every flag state
      for (int c = 0; c < 3; c++) begin
         step(1'b1, cc_vals[c], 3'b000, 1'b0, 1'b0);
         for (int m = 0; m < 8; m++) step(1'b0, 16'h0000, 3'(m), 1'b0, 1'b0);
      end

      // hold, then branch against old flags while loading new ones
      step(1'b1, 16'h0005, 3'b000, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 3'b000, 1'b0, 1'b0);
      chk("hold_cc", {29'd0, cc_out}, 32'd1);
      step(1'b1, 16'h8000, 3'b001, 1'b1, 1'b1);
      chk("simul_cc_next", {29'd0, cc_out}, 32'd4);

      // mid-cycle async reset after some activity
      step(1'b0, 16'h0000, 3'b111, 1'b1, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst_cc", {29'd0, cc_out}, 32'd2);
      chk("arst_branch_count", branch_count, 32'd0);
      chk("arst_mispredict_count", mispredict_count, 32'd0);
      nzp_in = 3'b010; br_valid = 1'b0; ld_cc = 1'b0;
      #1;
      chk("arst_brz", {31'd0, branch_enable}, 32'd1);
      nzp_in = 3'b100;
      #1;
      chk("arst_brn", {31'd0, branch_enable}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // first load straight after reset release
      step(1'b1, 16'h0000, 3'b000, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 3'b010, 1'b1, 1'b1);
      step(1'b0, 16'h0000, 3'b001, 1'b1, 1'b1);
      step(1'b0, 16'h0000, 3'b000, 1'b1, 1'b0);
      chk("three_branches", branch_count, 32'd3);
      chk("one_mispredict", mispredict_count, 32'd1);
      step(1'b0, 16'h0000, 3'b010, 1'b0, 1'b0);
      chk("idle_branch_count", branch_count, 32'd3);

      // narrow counters wrap from 7 to 0
      for (int k = 0; k < 4; k++) step(1'b0, 16'h0000, 3'b111, 1'b1, 1'b1);
      chk("small_at_max", {29'd0, bc_s}, 32'd7);
      step(1'b0, 16'h0000, 3'b111, 1'b1, 1'b1);
      chk("small_wrapped", {29'd0, bc_s}, 32'd0);
      chk("wide_no_wrap", branch_count, 32'd8);

      // randomized traffic
      for (int r = 0; r < 300; r++) begin
         rv = 16'($urandom);
         if ($urandom_range(0, 5) == 0) rv = 16'h0000;
         step(1'($urandom), rv, 3'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
